field_stream_extractor: RTL and testbench
=========================================

Name: field_stream_extractor

Overview:
- Parametrised successor to fixed-width indexed part-select extraction.
- Accepts a DATA_W-bit word plus a base index, stride, count and direction.
- Streams COUNT fields of FIELD_W bits out over a valid/ready interface, stepping the index by the stride each beat.
- Bits outside the word read as zero and are flagged, so a bench checks a defined value instead of X. Used as a field-unpacking stage ahead of datapath checkers.

Parameters:
- DATA_W, 16, width of the loaded word.
- FIELD_W, 4, width of each extracted field (1..DATA_W).
- IDX_W, 5, width of the index/stride registers; index arithmetic wraps modulo 2^IDX_W.
- CNT_W, 8, width of the field count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  load request.
- load_ready  out  1  high only in IDLE.
- load_data  in  DATA_W  word to extract from.
- load_base  in  IDX_W  first index.
- load_stride  in  IDX_W  index step per beat.
- load_count  in  CNT_W  number of fields to emit.
- load_desc  in  1  0 = ascending select (+:), 1 = descending select (-:).
- out_valid  out  1  field available.
- out_ready  in  1  consumer accepts field.
- out_data  out  FIELD_W  extracted field.
- out_oob  out  1  at least one bit of this field lies outside [0, DATA_W-1].
- out_last  out  1  final field of the current job.
- busy  out  1  job in progress (state RUN).

Behaviour:
- Reset (async, rst=1): state IDLE; word, idx, remaining and direction registers cleared.
  - Output values: out_valid=0, out_data=0, out_oob=0, out_last=0, busy=0, load_ready=1 once rst deasserts.
  - A job in flight is discarded with no partial output.
- States: IDLE, RUN.
- IDLE: load_ready=1. On load_valid&&load_ready:
  - capture word, idx=load_base, stride, remaining=load_count, desc.
  - If load_count==0: stay IDLE; nothing emitted; load_ready remains 1.
  - Otherwise go to RUN.
- RUN: load_ready=0, busy=1, out_valid=1. The first field is valid the cycle after the load handshake (latency 1).
- Field mapping. Bit position p is computed in signed arithmetic wide enough to hold idx-FIELD_W+1 and idx+FIELD_W-1.
  - Ascending: out_data[k] = word[idx+k].
  - Descending: out_data[k] = word[idx-FIELD_W+1+k].
  - Any p<0 or p>=DATA_W contributes 0 and sets out_oob.
- Stability: out_data, out_oob and out_last derive only from registered state. While out_valid&&!out_ready they hold stable.
- out_last = (remaining==1) while in RUN.
- On beat (out_valid&&out_ready):
  - If remaining==1: go to IDLE. out_valid drops the next cycle, and load_ready rises the same cycle.
  - Otherwise: remaining-=1 and idx = idx+stride (ascending) or idx-stride (descending), both modulo 2^IDX_W.
  - A wrapped index is not an error in itself; only its bits are range-checked.
- load_valid in RUN is ignored; inputs are not sampled.
- No back-to-back overlap: at least one IDLE cycle separates jobs.
- Stride 0 is legal: the same field repeats COUNT times.
- Outputs in IDLE: out_data=0, out_oob=0, out_last=0.

Test Plan:
- Ascending sweep. Load 16'h8421, base 0, stride 4, count 4, asc; out_ready=1 → out_data 1,2,4,8 on consecutive cycles starting 1 cycle after the handshake; out_last only on 8; out_oob=0 throughout; load_ready=1 the cycle after.
- Descending sweep. Load 16'h8421, base 15, stride 4, count 4, desc → out_data 8,4,2,1; out_oob=0; out_last on 1.
- Out-of-range fields:
  - asc, base 14, count 1 → out_data=4'h2, out_oob=1.
  - desc, base 2, count 1 → out_data=4'h2, out_oob=1.
  - asc, base 31 → out_data=0, out_oob=1.
- Backpressure. Ascending sweep with out_ready low for 3 cycles at beat 2 → out_data holds 2 with out_valid=1 for all 3 cycles; the sequence resumes 4,8 with no skipped or duplicated field.
- Count zero and stride zero:
  - count 0 → out_valid never rises; load_ready stays 1.
  - stride 0, base 4, count 3 → out_data 2,2,2, out_last on the third.
- Reset mid-job. Assert rst asynchronously after beat 1 of the ascending sweep → out_valid, busy and out_last drop immediately; after release, load_ready=1 and a fresh load emits from its own base.

Source files
------------

// File: rtl/field_stream_extractor.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | field_stream_extractor: streams strided FIELD_W-bit fields out of a word, |
// | zero-filling and flagging bits outside the word.          Revision: 1.0  |
// +---------------------------------------------------------------------------+
module field_stream_extractor #(
  parameter int DATA_W  = 16,
  parameter int FIELD_W = 4,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [DATA_W-1:0]  load_data,
  input  logic [IDX_W-1:0]   load_base,
  input  logic [IDX_W-1:0]   load_stride,
  input  logic [CNT_W-1:0]   load_count,
  input  logic               load_desc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_data,
  output logic               out_oob,
  output logic               out_last,
  output logic               busy
);

  localparam int AW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  // Two guard bits: one for idx+FIELD_W-1 overflow, one for the sign.
  localparam int PW = ((IDX_W > AW) ? IDX_W : AW) + 2;
  localparam logic signed [PW-1:0] C_FOFS   = PW'(FIELD_W - 1);
  localparam logic signed [PW-1:0] C_DATA_W = PW'(DATA_W);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   stride_q, stride_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               desc_q, desc_d;

  logic               w_run;
  logic               w_last;
  logic signed [PW-1:0] w_base;
  logic [FIELD_W-1:0] w_bits;
  logic [FIELD_W-1:0] w_oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      idx_q    <= '0;
      stride_q <= '0;
      rem_q    <= '0;
      desc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      desc_q   <= desc_d;
    end
  end

  assign w_run  = (state_q == S_RUN);
  assign w_last = (rem_q == CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    desc_d   = desc_q;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          word_d   = load_data;
          idx_d    = load_base;
          stride_d = load_stride;
          rem_d    = load_count;
          desc_d   = load_desc;
          state_d  = (load_count != '0) ? S_RUN : S_IDLE;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (w_last) begin
            rem_d   = '0;
            state_d = S_IDLE;
          end else begin
            rem_d = rem_q - CNT_W'(1);
            idx_d = desc_q ? (idx_q - stride_q) : (idx_q + stride_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Descending selects end at idx, so the lowest bit sits FIELD_W-1 below it.
  assign w_base = $signed({{(PW-IDX_W){1'b0}}, idx_q}) - (desc_q ? C_FOFS : PW'(0));

  for (genvar k = 0; k < FIELD_W; k++) begin : g_field
    logic signed [PW-1:0] w_pos;
    logic                 w_in;
    assign w_pos     = w_base + PW'(k);
    assign w_in      = !w_pos[PW-1] && (w_pos < C_DATA_W);
    assign w_bits[k] = w_in & word_q[w_pos[AW-1:0]];
    assign w_oob[k]  = !w_in;
  end

  assign load_ready = !w_run;
  assign busy       = w_run;
  assign out_valid  = w_run;
  assign out_data   = w_run ? w_bits : '0;
  assign out_oob    = w_run & (|w_oob);
  assign out_last   = w_run & w_last;

endmodule
`default_nettype wire

// File: tb/tb_field_stream_extractor.sv
`default_nettype none
// Scoreboard bench for field_stream_extractor: expected fields are queued at
// load time and compared as the DUT presents them.
module tb_field_stream_extractor;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [4:0]  load_base;
  logic [4:0]  load_stride;
  logic [7:0]  load_count;
  logic        load_desc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_oob;
  logic        out_last;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [5:0] q[$];  // {last, oob, data}

  field_stream_extractor #(
    .DATA_W(16), .FIELD_W(4), .IDX_W(5), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_base(load_base), .load_stride(load_stride),
    .load_count(load_count), .load_desc(load_desc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_oob(out_oob), .out_last(out_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // A held field (valid && !ready) is compared against the head without popping.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_field: got data=%h oob=%b last=%b, required no field",
                 out_data, out_oob, out_last);
      end else begin
        if ({out_last, out_oob, out_data} !== q[0]) begin
          bad++;
          $display("FAIL field: got last=%b oob=%b data=%h, required last=%b oob=%b data=%h",
                   out_last, out_oob, out_data, q[0][5], q[0][4], q[0][3:0]);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  function automatic logic [5:0] fld(input logic last, input logic oob, input logic [3:0] d);
    return {last, oob, d};
  endfunction

  task automatic do_load(input logic [15:0] d, input logic [4:0] b, input logic [4:0] s,
                         input logic [7:0] c, input logic dsc);
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_ready_idle: got %b, required 1", load_ready);
    end
    load_valid  = 1'b1;
    load_data   = d;
    load_base   = b;
    load_stride = s;
    load_count  = c;
    load_desc   = dsc;
    @(posedge clk);
    #1;
    load_valid  = 1'b0;
    load_data   = '0;
    load_base   = '0;
    load_stride = '0;
    load_count  = '0;
  endtask

  task automatic drain(input int n, input string name);
    for (int i = 0; i < n && q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d fields pending after %0d cycles, required 0",
               name, q.size(), n);
      q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: got valid=%b ready=%b busy=%b, required 0 1 0",
               name, out_valid, load_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_valid = 1'b0; load_data = '0; load_base = '0; load_stride = '0;
    load_count = '0; load_desc = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data, out_oob, out_last, busy, load_ready} !== 9'b0_0000_0_0_0_1) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h oob=%b last=%b busy=%b ready=%b, required 0 0 0 0 0 1",
               out_valid, out_data, out_oob, out_last, busy, load_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ascending();
    out_ready = 1'b1;
    q.push_back(fld(0, 0, 4'h1));
    q.push_back(fld(0, 0, 4'h2));
    q.push_back(fld(0, 0, 4'h4));
    q.push_back(fld(1, 0, 4'h8));
    do_load(16'h8421, 5'd0, 5'd4, 8'd4, 1'b0);
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0) begin
      bad++;
      $display("FAIL asc_latency: got valid=%b busy=%b ready=%b, required 1 1 0",
               out_valid, busy, load_ready);
    end
    drain(4, "asc");
    check_idle("asc");
  endtask

  task automatic test_descending();
    out_ready = 1'b1;
    q.push_back(fld(0, 0, 4'h8));
    q.push_back(fld(0, 0, 4'h4));
    q.push_back(fld(0, 0, 4'h2));
    q.push_back(fld(1, 0, 4'h1));
    do_load(16'h8421, 5'd15, 5'd4, 8'd4, 1'b1);
    drain(4, "desc");
    check_idle("desc");
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    q.push_back(fld(1, 1, 4'h2));
    do_load(16'h8421, 5'd14, 5'd0, 8'd1, 1'b0);
    drain(1, "oob_asc14");
    check_idle("oob_asc14");
    q.push_back(fld(1, 1, 4'h2));
    do_load(16'h8421, 5'd2, 5'd0, 8'd1, 1'b1);
    drain(1, "oob_desc2");
    check_idle("oob_desc2");
    q.push_back(fld(1, 1, 4'h0));
    do_load(16'h8421, 5'd31, 5'd0, 8'd1, 1'b0);
    drain(1, "oob_asc31");
    check_idle("oob_asc31");
    // Descending from 1 by 2 wraps the index to 31.
    q.push_back(fld(0, 1, 4'h4));
    q.push_back(fld(1, 1, 4'h0));
    do_load(16'h8421, 5'd1, 5'd2, 8'd2, 1'b1);
    drain(2, "wrap_desc");
    check_idle("wrap_desc");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    q.push_back(fld(0, 0, 4'h1));
    q.push_back(fld(0, 0, 4'h2));
    q.push_back(fld(0, 0, 4'h4));
    q.push_back(fld(1, 0, 4'h8));
    do_load(16'h8421, 5'd0, 5'd4, 8'd4, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 3 || out_valid !== 1'b1 || out_data !== 4'h2) begin
      bad++;
      $display("FAIL bp_hold: got pending=%0d valid=%b data=%h, required 3 1 2",
               q.size(), out_valid, out_data);
    end
    out_ready = 1'b1;
    drain(3, "bp");
    check_idle("bp");
  endtask

  task automatic test_count_zero();
    out_ready = 1'b1;
    do_load(16'h8421, 5'd0, 5'd4, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
        bad++;
        $display("FAIL count_zero: got valid=%b ready=%b, required 0 1", out_valid, load_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stride_zero();
    out_ready = 1'b1;
    q.push_back(fld(0, 0, 4'h2));
    q.push_back(fld(0, 0, 4'h2));
    q.push_back(fld(1, 0, 4'h2));
    do_load(16'h8421, 5'd4, 5'd0, 8'd3, 1'b0);
    drain(3, "stride0");
    check_idle("stride0");
  endtask

  task automatic test_reset_mid_job();
    out_ready = 1'b1;
    q.push_back(fld(0, 0, 4'h1));
    q.push_back(fld(0, 0, 4'h2));
    q.push_back(fld(0, 0, 4'h4));
    q.push_back(fld(1, 0, 4'h8));
    do_load(16'h8421, 5'd0, 5'd4, 8'd4, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got valid=%b busy=%b last=%b, required 0 0 0",
               out_valid, busy, out_last);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release: got load_ready=%b, required 1", load_ready);
    end
    @(posedge clk);
    #1;
    q.push_back(fld(0, 0, 4'h4));
    q.push_back(fld(1, 0, 4'h8));
    do_load(16'h8421, 5'd8, 5'd4, 8'd2, 1'b0);
    drain(2, "after_rst");
    check_idle("after_rst");
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_out_of_range();
    test_backpressure();
    test_count_zero();
    test_stride_zero();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
